// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request/response bus between the arbiter and main memory
// Signals:
//   mem_req_valid/ready   request handshake (arbiter -> memory)
//   mem_req_addr          word-aligned byte address
//   mem_req_rw            1 = write, 0 = read
//   mem_req_wmask         byte write mask
//   mem_req_data          write data
//   mem_resp_valid/data   one response per accepted request
// Modports: master = arbiter side, slave = memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic [ADDR_W-1:0] mem_req_addr;
    logic              mem_req_rw;
    logic [3:0]        mem_req_wmask;
    logic [31:0]       mem_req_data;
    logic              mem_resp_valid;
    logic [31:0]       mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_rw, mem_req_wmask, mem_req_data,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_rw, mem_req_wmask, mem_req_data,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port memory arbiter, data requests served before instruction fetch
// Ports:
//   clk          clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   icache_addr  fetch address; icache_re fetch request; icache_dout fetched word
//   dcache_addr  load/store address; dcache_re load; dcache_we store byte mask
//   dcache_din   store data; dcache_dout load data
//   stall        core freeze while a request is being served
//   mem          memory bus (mem_arbiter_if.master)
// Option: define MEM_ARBITER_WBUF_EN to compile in a 1-entry posted write buffer.
module mem_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              icache_re,
    output logic [31:0]       icache_dout,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_re,
    input  logic [3:0]        dcache_we,
    input  logic [31:0]       dcache_din,
    output logic [31:0]       dcache_dout,
    output logic              stall,
    mem_arbiter_if.master     mem
);
    typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE} state_t;

    localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    state_t state;
    logic   d_load;
    logic   store;
    logic   dreq;
    logic   post;
    logic   busy;

    assign store = |dcache_we;
    assign dreq  = dcache_re | store;

`ifdef MEM_ARBITER_WBUF_EN
    logic              wb_valid;
    logic              drain;
    logic [ADDR_W-1:0] wb_addr;
    logic [3:0]        wb_mask;
    logic [31:0]       wb_data;

    assign post = store & ~icache_re & ~wb_valid;
    // a drain is a background write: the core is only frozen if it wants the port
    assign busy = drain ? (dreq | icache_re) : 1'b1;
`else
    assign post = 1'b0;
    assign busy = 1'b1;
`endif

    assign stall = rst_n & ((state == IDLE) ? ((dreq | icache_re) & ~post)
                                            : (state != DONE) & busy);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            d_load            <= 1'b0;
            icache_dout       <= '0;
            dcache_dout       <= '0;
            mem.mem_req_valid <= 1'b0;
            mem.mem_req_addr  <= '0;
            mem.mem_req_rw    <= 1'b0;
            mem.mem_req_wmask <= '0;
            mem.mem_req_data  <= '0;
`ifdef MEM_ARBITER_WBUF_EN
            wb_valid          <= 1'b0;
            drain             <= 1'b0;
            wb_addr           <= '0;
            wb_mask           <= '0;
            wb_data           <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef MEM_ARBITER_WBUF_EN
                    // a full buffer is always emptied first so later loads see the store
                    if (wb_valid) begin
                        state             <= D_REQ;
                        drain             <= 1'b1;
                        d_load            <= 1'b0;
                        mem.mem_req_valid <= 1'b1;
                        mem.mem_req_addr  <= wb_addr;
                        mem.mem_req_rw    <= 1'b1;
                        mem.mem_req_wmask <= wb_mask;
                        mem.mem_req_data  <= wb_data;
                    end else if (post) begin
                        wb_valid          <= 1'b1;
                        wb_addr           <= dcache_addr & WORD_MASK;
                        wb_mask           <= dcache_we;
                        wb_data           <= dcache_din;
                    end else
`endif
                    if (dreq) begin
                        state             <= D_REQ;
                        d_load            <= ~store;
                        mem.mem_req_valid <= 1'b1;
                        mem.mem_req_addr  <= dcache_addr & WORD_MASK;
                        mem.mem_req_rw    <= store;
                        mem.mem_req_wmask <= dcache_we;
                        mem.mem_req_data  <= dcache_din;
                    end else if (icache_re) begin
                        state             <= I_REQ;
                        mem.mem_req_valid <= 1'b1;
                        mem.mem_req_addr  <= icache_addr & WORD_MASK;
                        mem.mem_req_rw    <= 1'b0;
                        mem.mem_req_wmask <= '0;
                        mem.mem_req_data  <= '0;
                    end
                end
                D_REQ: begin
                    if (mem.mem_req_ready) begin
                        state             <= D_WAIT;
                        mem.mem_req_valid <= 1'b0;
                    end
                end
                D_WAIT: begin
                    if (mem.mem_resp_valid) begin
                        if (d_load)
                            dcache_dout <= mem.mem_resp_data;
`ifdef MEM_ARBITER_WBUF_EN
                        if (drain) begin
                            state    <= IDLE;
                            drain    <= 1'b0;
                            wb_valid <= 1'b0;
                        end else
`endif
                        if (icache_re) begin
                            state             <= I_REQ;
                            mem.mem_req_valid <= 1'b1;
                            mem.mem_req_addr  <= icache_addr & WORD_MASK;
                            mem.mem_req_rw    <= 1'b0;
                            mem.mem_req_wmask <= '0;
                            mem.mem_req_data  <= '0;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                I_REQ: begin
                    if (mem.mem_req_ready) begin
                        state             <= I_WAIT;
                        mem.mem_req_valid <= 1'b0;
                    end
                end
                I_WAIT: begin
                    if (mem.mem_resp_valid) begin
                        icache_dout <= mem.mem_resp_data;
                        state       <= DONE;
                    end
                end
                // one cycle with stall low lets the core move past the held request
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 32, width of every address port; addresses are byte addresses, and bits [1:0] are forced to 0 on mem_req_addr.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 icache_addr  in  ADDR_W  fetch address from the core.
REQ-005 icache_re  in  1  fetch request.
REQ-006 icache_dout  out  32  fetched instruction word.
REQ-007 dcache_addr  in  ADDR_W  load/store address.
REQ-008 dcache_re  in  1  load request.
REQ-009 dcache_we  in  4  store byte mask; a nonzero value is a store.
REQ-010 dcache_din  in  32  store data.
REQ-011 dcache_dout  out  32  load data.
REQ-012 stall  out  1  core freeze; the core holds every request input stable while stall=1.
REQ-013 mem_req_valid / mem_req_ready  out / in  1 / 1  request handshake toward main memory.
REQ-014 mem_req_addr, mem_req_rw, mem_req_wmask, mem_req_data  out  ADDR_W / 1 / 4 / 32  request payload; rw=1 means write.
REQ-015 mem_resp_valid, mem_resp_data  in  1 / 32  one response per accepted request, including writes (write response data is ignored).

Function
REQ-016 The FSM states are IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT and DONE.
REQ-017 From IDLE with a data request (dcache_re or nonzero dcache_we), the FSM goes to D_REQ.
REQ-018 From IDLE with only icache_re, the FSM goes to I_REQ.
REQ-019 From IDLE with no request, the FSM stays in IDLE and stall is 0.
REQ-020 stall is combinational: 1 when IDLE sees a request that needs memory, 1 in every state except IDLE and DONE, and 0 in DONE.
REQ-021 In D_REQ and I_REQ, mem_req_valid is 1 and the payload is stable until the cycle where mem_req_valid and mem_req_ready are both 1; that cycle moves the FSM to the matching *_WAIT state.
REQ-022 In D_WAIT, mem_resp_valid captures mem_resp_data into dcache_dout (loads only), then the FSM goes to I_REQ if icache_re is set, else to DONE.
REQ-023 In I_WAIT, mem_resp_valid captures mem_resp_data into icache_dout, then the FSM goes to DONE.
REQ-024 DONE lasts exactly one cycle with stall=0, then returns to IDLE; a request the core presents in DONE is not re-served.
REQ-025 Data is always served before instruction fetch, so at most one memory request is outstanding at any time.
REQ-026 Best-case latency with mem_req_ready=1 and a response 1 cycle after acceptance is 3 cycles of stall for a single request and 5 cycles for D+I.
REQ-027 dcache_dout and icache_dout hold their last captured value until the next capture.
REQ-028 A mem_resp_valid that arrives outside a *_WAIT state is ignored.

Reset
REQ-029 Asserting reset (low) forces, asynchronously: state=IDLE, mem_req_valid=0, icache_dout=0, dcache_dout=0, and the write buffer to empty.
REQ-030 stall reads 0 during reset.
REQ-031 A transaction in flight when reset asserts is abandoned, and any response that arrives after reset releases is ignored.

Configuration
REQ-032 With macro MEM_ARBITER_WBUF_EN defined, a 1-entry posted write buffer is compiled in.
REQ-033 With the buffer: a store in IDLE with an empty buffer and no icache_re is captured into the buffer with stall=0.
REQ-034 With the buffer: the buffer drains via the memory port whenever the FSM is IDLE and no other request is present.
REQ-035 With the buffer: any load or fetch stalls until the buffer is empty, and a store arriving while the buffer is full stalls until the buffer is empty.
REQ-036 Without MEM_ARBITER_WBUF_EN, stores follow the blocking D_REQ/D_WAIT path exactly like loads.

Verification
REQ-037 Scenario: icache_re=1, addr 0x2000, memory ready, response 0x00000013 one cycle later -> stall high for 3 cycles, then icache_dout=0x00000013.
REQ-038 Scenario: dcache_re with addr 0x100 together with icache_re with addr 0x2004 -> the D request is issued before the I request, only one request is outstanding, and stall deasserts only in DONE.
REQ-039 Scenario: store, dcache_we=4'b0011, addr 0x102, data 0xBEEF -> mem_req_addr=0x100, mem_req_wmask=0011, rw=1.
REQ-040 Scenario: mem_req_ready held at 0 for 4 cycles -> the payload stays stable and stall stays 1 throughout.
REQ-041 Scenario: reset asserted during D_WAIT, then a late mem_resp_valid -> outputs read 0, the FSM is in IDLE, and the late response is ignored.
REQ-042 Scenario: with MEM_ARBITER_WBUF_EN, a store to 0x40 followed next cycle by a load from 0x40 -> the store shows no stall, the load stalls until the buffer drains, and the load returns the stored data.
